ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
Keyboard-side producer for the keyboard register. Deserializes PS/2 frames from the keyboard pins and decodes the E0/F0 prefixes into one 32-bit key-event word. Writes that word into the keyboard register via a one-cycle write-enable strobe. The register then holds the event with bit 31 as the "new key" flag until the processor clears it.

Parameters:
FILTER_LEN, 4, consecutive equal synchronized samples required to accept a PS2_CLK level change
TIMEOUT_CYCLES, 50000, max CLK cycles between PS2_CLK falling edges inside a frame before abort
CNT_W, 16, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
PS2_CLK  input  1  raw keyboard clock pin (asynchronous)
PS2_DATA  input  1  raw keyboard data pin (asynchronous)
FLAG_IN  input  1  bit 31 of keyboard register output (1 = previous event unread)
DATA_OUT  output  32  event word to register IN
WE_TECLADO  output  1  one-cycle write strobe to register WE_Teclado
FRAME_ERR  output  1  one-cycle pulse on parity, start or stop error, or timeout
OVERRUN  output  1  one-cycle pulse, coincident with WE_TECLADO, when FLAG_IN=1

Behaviour:
- Reset (synchronous): DATA_OUT=0, WE_TECLADO=0, FRAME_ERR=0, OVERRUN=0, FSM=IDLE, prefix flags cleared, synchronizers and filter loaded with 1.
- Input conditioning:
  - PS2_CLK and PS2_DATA each pass through a 2-flop synchronizer.
  - The filtered clock changes only after FILTER_LEN identical synchronized samples.
  - fall = filtered clock 1->0. Data is sampled from the synchronized PS2_DATA in the cycle fall is high.
- Frame FSM (advances only on fall):
  - IDLE: data=0 -> DATA, bit count=0. data=1 -> stay in IDLE, no error.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: require stop=1 and odd parity over the 8 data bits plus the parity bit. Then -> IDLE.
- Timeout:
  - The counter clears on every fall and increments each cycle in states other than IDLE.
  - Reaching TIMEOUT_CYCLES-1: FRAME_ERR pulse, -> IDLE, partial byte discarded, prefix flags kept.
- Byte decoder (on a good STOP, cycle N = the fall cycle):
  - 0xE0: set ext, no write.
  - 0xF0: set brk, no write.
  - Any other byte B: in cycle N+1, DATA_OUT={1'b1, 21'b0, ext, brk, B}, i.e. bit9=ext, bit8=brk, bits[7:0]=B, and WE_TECLADO=1 for exactly one cycle. ext and brk are cleared in the same cycle.
  - Any other byte B while FLAG_IN=1: OVERRUN=1 in cycle N+1. The write still happens (newest event wins).
- Bad STOP (parity or stop error): FRAME_ERR=1 in N+1, no write, ext and brk cleared.
- DATA_OUT holds its last value between writes.
- WE_TECLADO is never high in two consecutive cycles.
- Latency: write strobe 1 CLK after the stop-bit falling edge is detected. Total pin-to-strobe latency is 2 (sync) + FILTER_LEN + 1 cycles.
- RESET mid-frame aborts immediately. No strobe is emitted for the interrupted frame.
- The block never drives the PS/2 pins (receive-only, no host-to-device commands).

Decomposition:
- Shared package: constants for the prefix bytes (0xE0, 0xF0) and the event-word bit positions (FLAG=31, EXT=9, BRK=8, CODE=7:0), used by this block and by the processor-side software header.
- One natural sub-module, ps2_input_filter: synchronizer plus debounce plus falling-edge detect, instantiated for PS2_CLK, with a plain 2-flop sync for PS2_DATA.

Test Plan:
- Frame 0x1C (key "A", parity 0, stop 1), FLAG_IN=0 -> single WE_TECLADO pulse, DATA_OUT=0x8000001C, OVERRUN=0, FRAME_ERR=0.
- Sequence F0,1C -> no strobe after F0; strobe after 1C with DATA_OUT=0x8000011C.
- Sequence E0,F0,75 (release up-arrow) -> exactly one strobe, DATA_OUT=0x80000375, flags cleared (a following 0x75 gives 0x80000075).
- Frame 0x1C with parity bit inverted -> FRAME_ERR pulse, no WE_TECLADO, DATA_OUT unchanged. Prior E0 prefix is cleared.
- Five bits of a frame then PS2_CLK held high for TIMEOUT_CYCLES -> FRAME_ERR pulse, FSM in IDLE. The next valid 0x29 frame yields DATA_OUT=0x80000029.
- FLAG_IN=1, frame 0x5A -> WE_TECLADO and OVERRUN pulse together, DATA_OUT=0x8000005A. RESET asserted mid-frame -> all outputs 0, no strobe.

Source files
------------

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants for the PS/2 keyboard receiver and the key-event word layout.
// The processor-side software header mirrors these values.
package ps2_keyboard_rx_pkg;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    localparam int EVT_FLAG_BIT = 31;
    localparam int EVT_EXT_BIT  = 9;
    localparam int EVT_BRK_BIT  = 8;
    localparam int EVT_CODE_MSB = 7;
    localparam int EVT_CODE_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    function automatic logic [31:0] make_event(input logic ext, input logic brk,
                                               input logic [7:0] code);
        logic [31:0] evt;
        evt = '0;
        evt[EVT_FLAG_BIT] = 1'b1;
        evt[EVT_EXT_BIT] = ext;
        evt[EVT_BRK_BIT] = brk;
        evt[EVT_CODE_MSB:EVT_CODE_LSB] = code;
        return evt;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_filter.sv
// PS/2 clock conditioning: 2-flop synchronizer, run-length debounce and a
// registered pulse on each accepted 1->0 transition of the filtered level.
module ps2_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic pin,
    output logic fall
);

    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic [FLT_W-1:0] run_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
            fall    <= 1'b0;
            // Level flips on the FILTER_LEN-th consecutive differing sample.
            if (sync_p1 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == FLT_W'(FILTER_LEN - 1)) begin
                level   <= sync_p1;
                run_cnt <= '0;
                fall    <= level;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard deserializer; folds E0/F0 prefixes into a
// 32-bit key-event word and writes it to the keyboard register.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    input  logic        FLAG_IN,
    output logic [31:0] DATA_OUT,
    output logic        WE_TECLADO,
    output logic        FRAME_ERR,
    output logic        OVERRUN
);

    logic             clk_fall;
    logic             data_sync_p0;
    logic             data_sync_p1;
    frame_state_t     state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             par;
    logic             ext;
    logic             brk;
    logic [CNT_W-1:0] tcnt;

    ps2_input_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .CLK  (CLK),
        .RESET(RESET),
        .pin  (PS2_CLK),
        .fall (clk_fall)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            data_sync_p0 <= PS2_DATA;
            data_sync_p1 <= data_sync_p0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            tcnt       <= '0;
            DATA_OUT   <= '0;
            WE_TECLADO <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            WE_TECLADO <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;

            if (state == ST_IDLE || clk_fall) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            // A stalled frame is dropped but prefixes already seen survive.
            if (state != ST_IDLE && !clk_fall && tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                FRAME_ERR <= 1'b1;
                state     <= ST_IDLE;
            end else if (clk_fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_sync_p1) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {data_sync_p1, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par   <= data_sync_p1;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (data_sync_p1 && (^{shreg, par})) begin
                            if (shreg == PREFIX_EXT) begin
                                ext <= 1'b1;
                            end else if (shreg == PREFIX_BRK) begin
                                brk <= 1'b1;
                            end else begin
                                DATA_OUT   <= make_event(ext, brk, shreg);
                                WE_TECLADO <= 1'b1;
                                OVERRUN    <= FLAG_IN;
                                ext        <= 1'b0;
                                brk        <= 1'b0;
                            end
                        end else begin
                            FRAME_ERR <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: hand-built PS/2 frames, pulse counters
// on the outputs and expected event words written out by hand.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int CNT_W          = 16;
    localparam int HALF           = 20;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DATA = 1'b1;
    logic        FLAG_IN = 1'b0;
    logic [31:0] DATA_OUT;
    logic        WE_TECLADO;
    logic        FRAME_ERR;
    logic        OVERRUN;

    int n_chk = 0;
    int n_pass = 0;
    int we_cnt = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    int ovr_alone = 0;
    int we_double = 0;
    logic we_prev = 1'b0;

    ps2_keyboard_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .FLAG_IN   (FLAG_IN),
        .DATA_OUT  (DATA_OUT),
        .WE_TECLADO(WE_TECLADO),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WE_TECLADO) we_cnt++;
        if (FRAME_ERR) err_cnt++;
        if (OVERRUN) ovr_cnt++;
        if (OVERRUN && !WE_TECLADO) ovr_alone++;
        if (WE_TECLADO && we_prev) we_double++;
        we_prev = WE_TECLADO;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b, input bit measure, output int lat);
        PS2_DATA = b;
        repeat (HALF) @(negedge CLK);
        PS2_CLK = 1'b0;
        lat = 0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge CLK);
            if (measure && WE_TECLADO && lat == 0) lat = i;
        end
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, output int lat);
        logic [10:0] bits;
        int dummy;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(bits[i], 1'b0, dummy);
        send_bit(bits[10], 1'b1, lat);
        PS2_DATA = 1'b1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] bits;
        int dummy;
        bits = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i], 1'b0, dummy);
    endtask

    initial begin
        int lat;
        int we0, err0, ovr0;

        repeat (4) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_data", DATA_OUT, 32'h0);
        check("rst_we", {31'b0, WE_TECLADO}, 32'h0);
        check("rst_err", {31'b0, FRAME_ERR}, 32'h0);
        check("rst_ovr", {31'b0, OVERRUN}, 32'h0);

        // Plain make code.
        we0 = we_cnt; err0 = err_cnt; ovr0 = ovr_cnt;
        send_frame(8'h1C, 1'b0, lat);
        check("a_we", we_cnt - we0, 1);
        check("a_data", DATA_OUT, 32'h8000001C);
        check("a_ovr", ovr_cnt - ovr0, 0);
        check("a_err", err_cnt - err0, 0);
        check("a_latency", lat, 2 + FILTER_LEN + 1);

        // Break prefix.
        we0 = we_cnt;
        send_frame(8'hF0, 1'b0, lat);
        check("brk_prefix_we", we_cnt - we0, 0);
        send_frame(8'h1C, 1'b0, lat);
        check("brk_we", we_cnt - we0, 1);
        check("brk_data", DATA_OUT, 32'h8000011C);

        // Extended release.
        we0 = we_cnt;
        send_frame(8'hE0, 1'b0, lat);
        send_frame(8'hF0, 1'b0, lat);
        send_frame(8'h75, 1'b0, lat);
        check("ext_we", we_cnt - we0, 1);
        check("ext_data", DATA_OUT, 32'h80000375);
        send_frame(8'h75, 1'b0, lat);
        check("ext_cleared", DATA_OUT, 32'h80000075);

        // Parity error clears the pending E0.
        we0 = we_cnt; err0 = err_cnt;
        send_frame(8'hE0, 1'b0, lat);
        send_frame(8'h1C, 1'b1, lat);
        check("par_err", err_cnt - err0, 1);
        check("par_we", we_cnt - we0, 0);
        check("par_data", DATA_OUT, 32'h80000075);
        send_frame(8'h1C, 1'b0, lat);
        check("par_prefix_gone", DATA_OUT, 32'h8000001C);

        // Timeout after five bits.
        we0 = we_cnt; err0 = err_cnt;
        send_partial(8'h29, 5);
        PS2_DATA = 1'b1;
        repeat (TIMEOUT_CYCLES + 20) @(negedge CLK);
        check("to_err", err_cnt - err0, 1);
        check("to_we", we_cnt - we0, 0);
        send_frame(8'h29, 1'b0, lat);
        check("to_recover", DATA_OUT, 32'h80000029);
        check("to_recover_err", err_cnt - err0, 1);

        // Overrun while the previous event is unread.
        FLAG_IN = 1'b1;
        we0 = we_cnt; ovr0 = ovr_cnt;
        send_frame(8'h5A, 1'b0, lat);
        check("ovr_we", we_cnt - we0, 1);
        check("ovr_pulse", ovr_cnt - ovr0, 1);
        check("ovr_data", DATA_OUT, 32'h8000005A);
        FLAG_IN = 1'b0;

        // Reset in the middle of a frame.
        we0 = we_cnt;
        send_partial(8'h1C, 6);
        RESET = 1'b1;
        @(negedge CLK);
        check("mid_rst_data", DATA_OUT, 32'h0);
        check("mid_rst_we", {31'b0, WE_TECLADO}, 32'h0);
        check("mid_rst_err", {31'b0, FRAME_ERR}, 32'h0);
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (HALF * 6) @(negedge CLK);
        check("mid_rst_nostrobe", we_cnt - we0, 0);
        send_frame(8'h1C, 1'b0, lat);
        check("post_rst_data", DATA_OUT, 32'h8000001C);

        check("ovr_without_we", ovr_alone, 0);
        check("we_back_to_back", we_double, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
